// File: rtl/render_pkg.sv
// Shared types and constants for the render/game-logic memory scheduler.
// Beam geometry matches a 1344x806 total raster.
package render_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  localparam logic [10:0] H_TOTAL       = 11'd1344;
  localparam logic [9:0]  V_TOTAL       = 10'd806;
  localparam logic [9:0]  GL_FIRST_LINE = 10'd796;
  localparam logic [9:0]  GUARD_LINE    = 10'd805;

  typedef enum logic [1:0] {
    REN   = 2'd0,
    GL    = 2'd1,
    GUARD = 2'd2
  } state_t;

  typedef enum logic {
    OWN_REN = 1'b0,
    OWN_GL  = 1'b1
  } owner_t;

  function automatic logic at_line(
    input logic [10:0] x,
    input logic [9:0]  y,
    input logic [9:0]  line
  );
    return (x == 11'd0) && (y == line);
  endfunction

endpackage

// File: rtl/mem_return_pipe.sv
// Two-stage owner-tag pipeline that steers memory read data back to
// whichever requester issued the read, regardless of later ownership.
module mem_return_pipe
  import render_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_rd,
  input  owner_t            acc_owner,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  output logic              gl_rvalid,
  output logic [DATA_W-1:0] gl_rdata
);

  logic   v1;
  logic   v2;
  owner_t t1;
  owner_t t2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      t1 <= OWN_REN;
      t2 <= OWN_REN;
    end else begin
      v1 <= acc_rd;
      t1 <= acc_owner;
      v2 <= v1;
      t2 <= t1;
    end
  end

  // Memory data lands in the cycle after mem_en, aligned with stage 2
  assign rd_rvalid = v2 && (t2 == OWN_REN);
  assign gl_rvalid = v2 && (t2 == OWN_GL);
  assign rd_rdata  = rd_rvalid ? mem_rdata : '0;
  assign gl_rdata  = gl_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/render_scheduler.sv
// Time-slices a single-port memory between the renderer and game logic,
// giving game logic the vertical blanking lines 796..805.
module render_scheduler
  import render_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       beam_x,
  input  logic [9:0]        beam_y,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  input  logic              gl_req,
  input  logic              gl_we,
  input  logic [ADDR_W-1:0] gl_addr,
  input  logic [DATA_W-1:0] gl_wdata,
  output logic              gl_gnt,
  output logic              gl_rvalid,
  output logic [DATA_W-1:0] gl_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              frame_start,
  output logic [15:0]       gl_cycles,
  output logic              gl_overrun
);

  state_t state;
  state_t state_nx;
  logic   go_gl;
  logic   go_guard;
  logic   acc;
  logic   acc_we;
  logic   acc_rd;
  owner_t acc_owner;

  always_ff @(posedge clk) begin
    if (rst) state <= REN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_gnt   = 1'b0;
    gl_gnt   = 1'b0;
    go_gl    = 1'b0;
    go_guard = 1'b0;
    unique case (state)
      REN: begin
        rd_gnt = rd_req;
        if (at_line(beam_x, beam_y, GL_FIRST_LINE)) begin
          state_nx = GL;
          go_gl    = 1'b1;
        end
      end
      GL: begin
        gl_gnt = gl_req;
        if (at_line(beam_x, beam_y, GUARD_LINE)) begin
          state_nx = GUARD;
          go_guard = 1'b1;
        end
      end
      GUARD: begin
        rd_gnt = rd_req;
        if (at_line(beam_x, beam_y, 10'd0)) state_nx = REN;
      end
      default: state_nx = REN;
    endcase
    // Nothing is accepted while reset is held
    if (rst) begin
      rd_gnt   = 1'b0;
      gl_gnt   = 1'b0;
      go_gl    = 1'b0;
      go_guard = 1'b0;
    end
  end

  assign acc       = rd_gnt || gl_gnt;
  assign acc_we    = gl_gnt && gl_we;
  assign acc_rd    = acc && !acc_we;
  assign acc_owner = gl_gnt ? OWN_GL : OWN_REN;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= acc;
      mem_we <= acc_we;
      if (gl_gnt) begin
        mem_addr  <= gl_addr;
        mem_wdata <= gl_wdata;
      end else if (rd_gnt) begin
        mem_addr <= rd_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
      gl_cycles   <= '0;
      gl_overrun  <= 1'b0;
    end else begin
      frame_start <= go_gl;
      if (go_gl) begin
        gl_cycles <= '0;
      end else if (gl_gnt && (gl_cycles != 16'hFFFF)) begin
        gl_cycles <= gl_cycles + 16'd1;
      end
      // A request still waiting when the window closes is an overrun
      if (go_guard && gl_req) gl_overrun <= 1'b1;
    end
  end

  mem_return_pipe u_ret (
    .clk       (clk),
    .rst       (rst),
    .acc_rd    (acc_rd),
    .acc_owner (acc_owner),
    .mem_rdata (mem_rdata),
    .rd_rvalid (rd_rvalid),
    .rd_rdata  (rd_rdata),
    .gl_rvalid (gl_rvalid),
    .gl_rdata  (gl_rdata)
  );

endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench for render_scheduler with a read-return scoreboard
// and a small behavioural single-port memory.
module tb_render_scheduler;
  import render_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] beam_x;
  logic [9:0]  beam_y;
  logic        rd_req;
  logic [13:0] rd_addr;
  logic        rd_gnt;
  logic        rd_rvalid;
  logic [15:0] rd_rdata;
  logic        gl_req;
  logic        gl_we;
  logic [13:0] gl_addr;
  logic [15:0] gl_wdata;
  logic        gl_gnt;
  logic        gl_rvalid;
  logic [15:0] gl_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        frame_start;
  logic [15:0] gl_cycles;
  logic        gl_overrun;

  render_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .beam_x      (beam_x),
    .beam_y      (beam_y),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_rvalid   (rd_rvalid),
    .rd_rdata    (rd_rdata),
    .gl_req      (gl_req),
    .gl_we       (gl_we),
    .gl_addr     (gl_addr),
    .gl_wdata    (gl_wdata),
    .gl_gnt      (gl_gnt),
    .gl_rvalid   (gl_rvalid),
    .gl_rdata    (gl_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .frame_start (frame_start),
    .gl_cycles   (gl_cycles),
    .gl_overrun  (gl_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        gl;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;

  logic [15:0] wmem [logic [13:0]];

  function automatic logic [15:0] pre(input logic [13:0] a);
    case (a)
      14'h0123: return 16'hBEEF;
      14'h0200: return 16'h1111;
      14'h0201: return 16'h2222;
      14'h0202: return 16'h3333;
      14'h0203: return 16'h4444;
      14'h0042: return 16'h4242;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) wmem[mem_addr] = mem_wdata;
    if (mem_en && !mem_we)
      mem_rdata <= wmem.exists(mem_addr) ? wmem[mem_addr] : pre(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic push(input logic gl, input logic [15:0] d);
    sb.push_back('{gl: gl, data: d, due: cyc + 2});
  endtask

  task automatic beam(input int x, input int y);
    beam_x = 11'(x);
    beam_y = 10'(y);
  endtask

  // Read-return monitor: every rvalid must match the head entry's cycle
  always @(negedge clk) begin
    if (mon_en) begin
      chk("gnt_exclusive", 32'(rd_gnt && gl_gnt), 32'd0);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.gl) begin
          chk("gl_rvalid", 32'(gl_rvalid), 32'd1);
          chk("gl_rdata", 32'(gl_rdata), 32'(e.data));
          chk("rd_rvalid_quiet", 32'(rd_rvalid), 32'd0);
        end else begin
          chk("rd_rvalid", 32'(rd_rvalid), 32'd1);
          chk("rd_rdata", 32'(rd_rdata), 32'(e.data));
          chk("gl_rvalid_quiet", 32'(gl_rvalid), 32'd0);
        end
      end else begin
        chk("no_rvalid", 32'(rd_rvalid || gl_rvalid), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    beam(0, 0);
    rd_req = 1'b1;
    rd_addr = 14'h0;
    gl_req = 1'b0;
    gl_we = 1'b0;
    gl_addr = 14'h0;
    gl_wdata = 16'h0;
    @(posedge clk);
    #1;
    repeat (3) tick();
    samp();
    chk("rst_rd_gnt", 32'(rd_gnt), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(REN));
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_gl_cycles", 32'(gl_cycles), 32'd0);
    chk("rst_overrun", 32'(gl_overrun), 32'd0);
    chk("rst_rvalid", 32'({rd_rvalid, gl_rvalid}), 32'd0);
    tick();
    rst = 1'b0;
    rd_req = 1'b0;
    mon_en = 1'b1;

    // Renderer read in REN
    beam(10, 100);
    rd_req = 1'b1;
    rd_addr = 14'h0123;
    samp();
    chk("ren_rd_gnt", 32'(rd_gnt), 32'd1);
    chk("ren_gl_gnt", 32'(gl_gnt), 32'd0);
    push(1'b0, 16'hBEEF);
    tick();
    rd_req = 1'b0;
    samp();
    chk("ren_mem_en", 32'(mem_en), 32'd1);
    chk("ren_mem_we", 32'(mem_we), 32'd0);
    chk("ren_mem_addr", 32'(mem_addr), 32'h0123);
    tick();
    samp();
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_addr_hold", 32'(mem_addr), 32'h0123);
    tick();

    // Game-logic request stalls until the window opens
    gl_req = 1'b1;
    gl_addr = 14'h0200;
    beam(0, 700);
    samp();
    chk("stall_700", 32'(gl_gnt), 32'd0);
    tick();
    beam(100, 795);
    samp();
    chk("stall_795", 32'(gl_gnt), 32'd0);
    tick();
    beam(0, 796);
    samp();
    chk("stall_796", 32'(gl_gnt), 32'd0);
    chk("state_ren_796", 32'(dut.state), 32'(REN));
    tick();
    beam(1, 796);
    rd_req = 1'b1;
    rd_addr = 14'h0042;
    samp();
    chk("gl_state", 32'(dut.state), 32'(GL));
    chk("frame_start_1", 32'(frame_start), 32'd1);
    chk("gl_gnt_1", 32'(gl_gnt), 32'd1);
    chk("rd_stall_gl", 32'(rd_gnt), 32'd0);
    chk("gl_cycles_clr", 32'(gl_cycles), 32'd0);
    push(1'b1, 16'h1111);
    tick();
    beam(2, 796);
    gl_we = 1'b1;
    gl_addr = 14'h0300;
    gl_wdata = 16'hCAFE;
    samp();
    chk("frame_start_0", 32'(frame_start), 32'd0);
    chk("gl_gnt_2", 32'(gl_gnt), 32'd1);
    chk("gl_rd_mem_addr", 32'(mem_addr), 32'h0200);
    chk("gl_rd_mem_we", 32'(mem_we), 32'd0);
    tick();
    gl_we = 1'b0;
    gl_addr = 14'h0201;
    samp();
    chk("gl_wr_mem_we", 32'(mem_we), 32'd1);
    chk("gl_wr_mem_addr", 32'(mem_addr), 32'h0300);
    chk("gl_wr_mem_wdata", 32'(mem_wdata), 32'hCAFE);
    push(1'b1, 16'h2222);
    tick();
    gl_addr = 14'h0300;
    samp();
    push(1'b1, 16'hCAFE);
    tick();
    gl_we = 1'b1;
    gl_addr = 14'h0301;
    gl_wdata = 16'h0055;
    samp();
    chk("gl_gnt_5", 32'(gl_gnt), 32'd1);
    tick();
    gl_req = 1'b0;
    gl_we = 1'b0;
    samp();
    chk("gl_cycles_5", 32'(gl_cycles), 32'd5);
    chk("gl_wr2_addr", 32'(mem_addr), 32'h0301);
    chk("gl_wr2_wdata", 32'(mem_wdata), 32'h0055);
    tick();
    samp();
    chk("gl_idle_en", 32'({mem_en, mem_we}), 32'd0);
    chk("gl_idle_wdata", 32'(mem_wdata), 32'h0055);
    tick();

    // Read accepted in the last GL cycle, request held into GUARD
    beam(0, 805);
    gl_req = 1'b1;
    gl_addr = 14'h0202;
    samp();
    chk("last_gl_gnt", 32'(gl_gnt), 32'd1);
    push(1'b1, 16'h3333);
    tick();
    beam(1, 805);
    samp();
    chk("guard_state", 32'(dut.state), 32'(GUARD));
    chk("guard_gl_gnt", 32'(gl_gnt), 32'd0);
    chk("overrun_set", 32'(gl_overrun), 32'd1);
    chk("gl_cycles_6", 32'(gl_cycles), 32'd6);
    chk("guard_rd_gnt", 32'(rd_gnt), 32'd1);
    push(1'b0, 16'h4242);
    tick();
    rd_req = 1'b0;
    samp();
    chk("guard_mem_addr", 32'(mem_addr), 32'h0042);
    chk("guard_gl_stall", 32'(gl_gnt), 32'd0);
    repeat (2) tick();
    samp();
    chk("overrun_hold", 32'(gl_overrun), 32'd1);
    chk("gl_cycles_hold", 32'(gl_cycles), 32'd6);
    tick();
    beam(0, 0);
    samp();
    chk("guard_at_0", 32'(dut.state), 32'(GUARD));
    tick();
    beam(1, 0);
    samp();
    chk("ren_again", 32'(dut.state), 32'(REN));
    chk("ren_gl_stall", 32'(gl_gnt), 32'd0);
    chk("overrun_sticky", 32'(gl_overrun), 32'd1);
    tick();

    // Second frame: held request granted at window open
    beam(0, 796);
    samp();
    tick();
    beam(1, 796);
    samp();
    chk("f2_frame_start", 32'(frame_start), 32'd1);
    chk("f2_gl_cycles_clr", 32'(gl_cycles), 32'd0);
    chk("f2_gl_gnt", 32'(gl_gnt), 32'd1);
    push(1'b1, 16'h3333);
    tick();
    gl_req = 1'b0;
    samp();
    chk("f2_gl_cycles_1", 32'(gl_cycles), 32'd1);
    repeat (3) tick();
    gl_req = 1'b1;
    gl_addr = 14'h0203;
    samp();
    chk("f2_rd_before_rst", 32'(gl_gnt), 32'd1);
    tick();

    // Reset one cycle after a GL read: its data must never return
    rst = 1'b1;
    gl_req = 1'b0;
    sb.delete();
    samp();
    chk("rst_gl_gnt", 32'(gl_gnt), 32'd0);
    tick();
    samp();
    chk("rst2_state", 32'(dut.state), 32'(REN));
    chk("rst2_gl_rvalid", 32'(gl_rvalid), 32'd0);
    chk("rst2_mem", 32'({mem_en, mem_we, mem_addr}), 32'd0);
    chk("rst2_wdata", 32'(mem_wdata), 32'd0);
    chk("rst2_counters",
        32'({frame_start, gl_overrun, gl_cycles}), 32'd0);
    tick();
    rst = 1'b0;
    beam(5, 796);
    samp();
    tick();
    beam(0, 797);
    samp();
    chk("post_rst_ren", 32'(dut.state), 32'(REN));
    tick();
    beam(0, 796);
    samp();
    tick();
    beam(1, 796);
    samp();
    chk("post_rst_gl", 32'(dut.state), 32'(GL));
    chk("post_rst_fs", 32'(frame_start), 32'd1);
    repeat (4) tick();
    samp();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/render_scheduler.md
RENDER_SCHEDULER -- requirements
Module: render_scheduler

Interface
REQ-001 SHALL have: clk  input  1  system/pixel clock.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: beam_x  input  11  horizontal beam counter, range 0..1343.
REQ-004 SHALL have: beam_y  input  10  vertical beam counter, range 0..805.
REQ-005 SHALL have: rd_req  input  1  renderer read request; rd_addr  input  14  renderer read address.
REQ-006 SHALL have: rd_gnt  output  1  renderer request accepted this cycle.
REQ-007 SHALL have: rd_rvalid  output  1  rd_rdata valid; rd_rdata  output  16  renderer read data.
REQ-008 SHALL have: gl_req  input  1  game-logic request; gl_we  input  1  write enable; gl_addr  input  14; gl_wdata  input  16.
REQ-009 SHALL have: gl_gnt  output  1  game-logic request accepted this cycle.
REQ-010 SHALL have: gl_rvalid  output  1  gl_rdata valid; gl_rdata  output  16  game-logic read data.
REQ-011 SHALL have: mem_en, mem_we  output  1 each; mem_addr  output  14; mem_wdata  output  16; mem_rdata  input  16; single-port memory, 1-cycle read latency.
REQ-012 SHALL have: frame_start  output  1  one-cycle pulse opening the game-logic window.
REQ-013 SHALL have: gl_cycles  output  16  accepted game-logic accesses in last window; gl_overrun  output  1  sticky overrun flag.

Function
REQ-014 FSM states SHALL be REN (renderer owns memory), GL (game logic owns), GUARD (renderer owns, game logic drained).
REQ-015 REN->GL SHALL occur at the clock edge after a cycle with beam_y==796 and beam_x==0; frame_start SHALL be 1 during the first GL cycle only.
REQ-016 GL->GUARD SHALL occur at the edge after a cycle with beam_y==805 and beam_x==0.
REQ-017 GUARD->REN SHALL occur at the edge after a cycle with beam_y==0 and beam_x==0.
REQ-018 rd_gnt SHALL equal rd_req and (state==REN or state==GUARD), combinationally; gl_gnt SHALL equal gl_req and state==GL; both never 1 together.
REQ-019 Accepted access SHALL drive mem_en/mem_we/mem_addr/mem_wdata registered on the next edge; renderer accesses SHALL have mem_we=0.
REQ-020 Read data SHALL return with rd_rvalid or gl_rvalid asserted exactly 2 cycles after acceptance, routed by a registered owner tag, independent of later state changes.
REQ-021 Accepted writes SHALL produce no rvalid.
REQ-022 Idle cycles SHALL drive mem_en=0, mem_we=0; address/data hold previous values.
REQ-023 gl_cycles SHALL count accepted game-logic accesses in GL (saturating at 16'hFFFF), clear on frame_start, and hold from GL exit until next frame_start.
REQ-024 gl_overrun SHALL set at GL->GUARD if gl_req==1 in the last GL cycle and clear only on rst.
REQ-025 Requests in the non-owning window SHALL stall (gnt=0) without loss; requesters hold signals until granted.

Reset
REQ-026 rst SHALL force state REN, all outputs 0, owner tags and counters 0, discarding in-flight reads (no rvalid after rst).
REQ-027 First GL window after rst SHALL open only at the next beam_y==796, beam_x==0.

Structure
REQ-028 Package render_pkg SHALL hold the state enum, H_TOTAL=1344, V_TOTAL=806, GL_FIRST_LINE=796, GUARD_LINE=805, ADDR_W=14, DATA_W=16.
REQ-029 Sub-module mem_return_pipe SHALL implement the 2-stage owner-tag/rvalid pipeline.

Verification
REQ-030 Reset, sweep beam to (796,0): frame_start=1 exactly one cycle later, state GL.
REQ-031 In REN, rd_req addr 0x0123, mem_rdata 0xBEEF: rd_gnt same cycle, mem_addr=0x0123 next, rd_rvalid=1 with 0xBEEF two cycles after grant.
REQ-032 gl_req held from (700,0): gl_gnt=0 until GL entry, then 1; 5 accepted accesses -> gl_cycles=5.
REQ-033 gl_req high through (805,0): gl_gnt drops in GUARD, gl_overrun=1 and stays 1 until rst.
REQ-034 gl read accepted in last GL cycle: gl_rvalid still arrives 2 cycles later during GUARD; rd_rvalid stays 0.
REQ-035 rst asserted 1 cycle after gl read accepted: no gl_rvalid, all outputs 0, state REN.
